// File: rtl/hub75_bcm_scan_pkg.sv
// Shared definitions for the HUB75 BCM scan controller: FSM state encoding,
// RGB555 field offsets and the hub_rgb bit-order helper.
package hub75_bcm_scan_pkg;

  // Scan sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_WAIT  = 3'd2,
    ST_BLANK = 3'd3,
    ST_LATCH = 3'd4
  } scan_state_t;

  // RGB555 field offsets inside one 15-bit pixel (bit 15 of each half is padding)
  localparam int R_OFF = 10;
  localparam int G_OFF = 5;
  localparam int B_OFF = 0;

  // Extract one bit-plane from a top/bottom pixel pair in panel pin order
  // {r1,g1,b1,r2,g2,b2}. Planes beyond 4 do not exist for a 5-bit channel.
  function automatic logic [5:0] plane_bits(input logic [14:0] top,
                                            input logic [14:0] bot,
                                            input logic [2:0]  plane);
    logic [4:0] r_top;
    logic [4:0] g_top;
    logic [4:0] b_top;
    logic [4:0] r_bot;
    logic [4:0] g_bot;
    logic [4:0] b_bot;
    r_top = top[R_OFF +: 5];
    g_top = top[G_OFF +: 5];
    b_top = top[B_OFF +: 5];
    r_bot = bot[R_OFF +: 5];
    g_bot = bot[G_OFF +: 5];
    b_bot = bot[B_OFF +: 5];
    plane_bits = {r_top[plane], g_top[plane], b_top[plane],
                  r_bot[plane], g_bot[plane], b_bot[plane]};
  endfunction

endpackage

// File: rtl/hub75_bcm_scan_oe_timer.sv
// Display on-time timer. A load sets the remaining on-time; the count then
// decrements every clock. The panel is lit (blank=0) exactly while the count
// is non-zero, so a load of N gives N lit clocks.
module hub75_bcm_scan_oe_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             blank
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  // Next count: load wins, otherwise count down to zero and hold
  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_val;
    end else if (count != {CNT_W{1'b0}}) begin
      count_next = count - CNT_W'(1);
    end else begin
      count_next = count;
    end
  end

  // Counter and registered blank; reset blanks the panel immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= {CNT_W{1'b0}};
      blank <= 1'b1;
    end else begin
      count <= count_next;
      blank <= (count_next == {CNT_W{1'b0}});
    end
  end

  assign busy = (count != {CNT_W{1'b0}});

endmodule

// File: rtl/hub75_bcm_scan.sv
// HUB75 binary-coded-modulation scan controller. Reads one row of pixel pairs
// from pixram per bit-plane, shifts that plane into the panel, latches it and
// lights it for BASE_ON<<plane clocks. Shifting the next plane overlaps the
// on-time of the current one; a plane is only latched once the previous
// on-time has expired.
module hub75_bcm_scan
  import hub75_bcm_scan_pkg::*;
#(
  parameter int COL_BITS = 6,
  parameter int ROW_BITS = 4,
  parameter int PLANES   = 5,
  parameter int BASE_ON  = 4,
  parameter int RAM_LAT  = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  output logic [ROW_BITS+COL_BITS-1:0] ram_raddr,
  input  logic [31:0]                  ram_rdata,
  output logic                         hub_clk,
  output logic                         hub_lat,
  output logic                         hub_oe,
  output logic [5:0]                   hub_rgb,
  output logic [ROW_BITS-1:0]          hub_row,
  output logic                         frame_start
);

  localparam int NCOL      = 1 << COL_BITS;
  // RAM_LAT fill cycles followed by two clocks per column
  localparam int SHIFT_LEN = 2 * NCOL + RAM_LAT;
  localparam int SC_W      = $clog2(SHIFT_LEN);
  // Wide enough for BASE_ON << (PLANES-1)
  localparam int CNT_W     = $clog2(BASE_ON + 1) + PLANES - 1;

  scan_state_t         state;
  logic [ROW_BITS-1:0] row;
  logic [2:0]          plane;
  logic [COL_BITS-1:0] col;
  logic [SC_W-1:0]     sc;

  int                  sc_i;
  logic                last_shift;
  logic                clk_rise;
  logic                rgb_load;
  logic                plane_last;
  logic                frame_wrap;
  logic [2:0]          next_plane;
  logic [ROW_BITS-1:0] next_row;
  logic [CNT_W-1:0]    on_time;
  logic                timer_load;
  logic                timer_busy;
  logic                unused_bits;

  // Padding bits of each RGB555 half carry no colour
  assign unused_bits = ram_rdata[31] ^ ram_rdata[15];

  // Shift-cycle decode and next row/plane selection.
  // Shift cycle s: column k is shown at s=RAM_LAT+2k (hub_clk low, new data)
  // and clocked at s=RAM_LAT+2k+1 (hub_clk high). hub_rgb is a register, so
  // it is loaded on the edge ending s=RAM_LAT+2k-1 from ram_rdata, which in
  // turn needs the column address RAM_LAT clocks before that edge.
  always_comb begin
    sc_i       = int'(sc);
    last_shift = (sc_i == SHIFT_LEN - 1);
    if ((sc_i >= RAM_LAT) && (sc_i <= RAM_LAT + 2 * NCOL - 2) &&
        (((sc_i - RAM_LAT) % 2) == 0)) begin
      clk_rise = 1'b1;
    end else begin
      clk_rise = 1'b0;
    end
    if ((sc_i >= RAM_LAT - 1) && (sc_i <= RAM_LAT + 2 * NCOL - 3) &&
        (((sc_i - RAM_LAT + 1) % 2) == 0)) begin
      rgb_load = 1'b1;
    end else begin
      rgb_load = 1'b0;
    end
    plane_last = (plane == 3'(PLANES - 1));
    frame_wrap = plane_last && (row == {ROW_BITS{1'b1}});
    if (plane_last) begin
      next_plane = 3'd0;
      next_row   = row + ROW_BITS'(1);
    end else begin
      next_plane = plane + 3'd1;
      next_row   = row;
    end
    on_time = CNT_W'(BASE_ON) << plane;
  end

  // The on-time of the plane just latched starts on the clock after LATCH
  assign timer_load = (state == ST_LATCH);

  hub75_bcm_scan_oe_timer #(
    .CNT_W (CNT_W)
  ) u_oe_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .load_val (on_time),
    .busy     (timer_busy),
    .blank    (hub_oe)
  );

  // Scan sequencer: state, row/plane/column counters and registered panel pins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      row         <= {ROW_BITS{1'b0}};
      plane       <= 3'd0;
      col         <= {COL_BITS{1'b0}};
      sc          <= {SC_W{1'b0}};
      ram_raddr   <= {(ROW_BITS + COL_BITS){1'b0}};
      hub_clk     <= 1'b0;
      hub_lat     <= 1'b0;
      hub_rgb     <= 6'b000000;
      hub_row     <= {ROW_BITS{1'b0}};
      frame_start <= 1'b0;
    end else begin
      hub_lat     <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          hub_clk <= 1'b0;
          if (enable) begin
            state       <= ST_SHIFT;
            row         <= {ROW_BITS{1'b0}};
            plane       <= 3'd0;
            col         <= {COL_BITS{1'b0}};
            sc          <= {SC_W{1'b0}};
            ram_raddr   <= {(ROW_BITS + COL_BITS){1'b0}};
            frame_start <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          hub_clk <= clk_rise;
          if (rgb_load) begin
            hub_rgb <= plane_bits(ram_rdata[30:16], ram_rdata[14:0], plane);
          end
          // Each column address is held for two clocks, advancing after even cycles
          if (!sc[0]) begin
            col       <= col + COL_BITS'(1);
            ram_raddr <= {row, col + COL_BITS'(1)};
          end
          if (last_shift) begin
            sc    <= {SC_W{1'b0}};
            state <= timer_busy ? ST_WAIT : ST_BLANK;
          end else begin
            sc <= sc + SC_W'(1);
          end
        end
        ST_WAIT: begin
          if (!timer_busy) begin
            state <= ST_BLANK;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_BLANK: begin
          // Row select moves only while blanked; prefetch column 0 of the next row
          hub_row   <= row;
          hub_lat   <= 1'b1;
          col       <= {COL_BITS{1'b0}};
          ram_raddr <= {next_row, {COL_BITS{1'b0}}};
          state     <= ST_LATCH;
        end
        ST_LATCH: begin
          plane <= next_plane;
          row   <= next_row;
          sc    <= {SC_W{1'b0}};
          if (frame_wrap && !enable) begin
            state <= ST_IDLE;
          end else begin
            state       <= ST_SHIFT;
            frame_start <= frame_wrap;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Scoreboard bench for hub75_bcm_scan: the stimulus process queues the
// expected latch contents per row/plane, a negedge monitor pops and compares
// on every hub_lat pulse and on every end of an OE-low window.
module tb_hub75_bcm_scan;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [9:0]  ram_raddr;
  logic [31:0] ram_rdata;
  logic        hub_clk;
  logic        hub_lat;
  logic        hub_oe;
  logic [5:0]  hub_rgb;
  logic [3:0]  hub_row;
  logic        frame_start;

  localparam int FRAME_CYC = 16 * 5 * (2 * 64 + 1 + 2);

  typedef struct {
    logic [3:0]   row;
    int           plane;
    int           width;
    logic [383:0] data;
  } exp_t;

  exp_t   exp_q[$];
  int     fs_cyc[$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     fs_count = 0;
  int     rise_cnt = 0;
  int     oe_run = 0;
  int     pend_w = -1;
  logic   prev_clk = 1'b0;
  logic   prev_oe = 1'b1;
  logic [3:0]   prev_row = 4'd0;
  logic [383:0] cap = '0;
  exp_t   mon_e;

  hub75_bcm_scan dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .ram_raddr   (ram_raddr),
    .ram_rdata   (ram_rdata),
    .hub_clk     (hub_clk),
    .hub_lat     (hub_lat),
    .hub_oe      (hub_oe),
    .hub_rgb     (hub_rgb),
    .hub_row     (hub_row),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Sparse pixram contents, {row,col} addressed, one clock read latency
  function automatic logic [31:0] pix_word(input logic [9:0] a);
    case (a)
      10'h0C7: pix_word = {16'h5400, 16'h3267}; // row 3 col 7
      10'h240: pix_word = {16'h03E0, 16'h0000}; // row 9 col 0
      10'h33F: pix_word = {16'h0001, 16'h4000}; // row 12 col 63
      default: pix_word = 32'h0000_0000;
    endcase
  endfunction

  always @(posedge clock) ram_rdata <= pix_word(ram_raddr);

  // Hand-derived {r1,g1,b1,r2,g2,b2} for each row/plane/column
  function automatic logic [5:0] exp_pix(input int r, input int p, input int c);
    exp_pix = 6'b000000;
    if (r == 3 && c == 7) begin
      case (p)
        0: exp_pix = 6'b100011;
        1: exp_pix = 6'b000011;
        2: exp_pix = 6'b100101;
        3: exp_pix = 6'b000100;
        4: exp_pix = 6'b100010;
        default: exp_pix = 6'b000000;
      endcase
    end else if (r == 9 && c == 0) begin
      exp_pix = 6'b010000;
    end else if (r == 12 && c == 63) begin
      if (p == 0) exp_pix = 6'b001000;
      else if (p == 4) exp_pix = 6'b000100;
    end
  endfunction

  function automatic int exp_width(input int p);
    case (p)
      0: exp_width = 4;
      1: exp_width = 8;
      2: exp_width = 16;
      3: exp_width = 32;
      4: exp_width = 64;
      default: exp_width = 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push_frame();
    exp_t e;
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p < 5; p++) begin
        e.row   = 4'(r);
        e.plane = p;
        e.width = exp_width(p);
        e.data  = '0;
        for (int c = 0; c < 64; c++) e.data[c*6 +: 6] = exp_pix(r, p, c);
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: compares DUT pin activity against the queued expectations
  always @(negedge clock) begin
    if (reset) begin
      rise_cnt = 0;
      oe_run   = 0;
      pend_w   = -1;
      cap      = '0;
      prev_clk = 1'b0;
      prev_oe  = 1'b1;
      prev_row = hub_row;
    end else begin
      if (hub_clk && !prev_clk) begin
        if (rise_cnt < 64) cap[rise_cnt*6 +: 6] = hub_rgb;
        rise_cnt++;
      end
      if (hub_lat) begin
        check("lat_clk_exclusive", 64'(hub_clk), 64'd0);
        check("lat_oe_blank", 64'(hub_oe), 64'd1);
        check("latch_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("hclk_rises_per_plane", 64'(rise_cnt), 64'd64);
          check("latched_row", 64'(hub_row), 64'(mon_e.row));
          n_checks++;
          if (cap !== mon_e.data) begin
            n_fail++;
            $display("FAIL plane_data row%0d plane%0d: got %h expected %h",
                     mon_e.row, mon_e.plane, cap, mon_e.data);
          end
          pend_w = mon_e.width;
        end
        rise_cnt = 0;
        cap      = '0;
      end
      if (!hub_oe) begin
        oe_run++;
      end else if (oe_run > 0) begin
        check("oe_low_width", 64'(oe_run), 64'(pend_w));
        oe_run = 0;
        pend_w = -1;
      end
      if (hub_row != prev_row) check("row_change_blanked", 64'({prev_oe, hub_oe}), 64'd3);
      if (frame_start) begin
        fs_count++;
        fs_cyc.push_back(cyc);
        check("frame_start_raddr", 64'(ram_raddr), 64'd0);
      end
      prev_clk = hub_clk;
      prev_oe  = hub_oe;
      prev_row = hub_row;
    end
  end

  task automatic wait_fs(input int target, input int budget);
    int n;
    n = 0;
    while (fs_count < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("wait_frame_start", 64'(fs_count >= target), 64'd1);
  endtask

  task automatic wait_q_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("wait_queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic idle_window(input int len);
    int low;
    low = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clock);
      if (!hub_oe) low++;
    end
    check("idle_oe_low_cycles", 64'(low), 64'd0);
    check("idle_hclk_rises", 64'(rise_cnt), 64'd0);
    check("idle_hub_oe", 64'(hub_oe), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_hub_oe", 64'(hub_oe), 64'd1);
    check("rst_hub_clk", 64'(hub_clk), 64'd0);
    check("rst_hub_lat", 64'(hub_lat), 64'd0);
    check("rst_hub_rgb", 64'(hub_rgb), 64'd0);
    check("rst_hub_row", 64'(hub_row), 64'd0);
    check("rst_ram_raddr", 64'(ram_raddr), 64'd0);
    check("rst_frame_start", 64'(frame_start), 64'd0);

    // First plane, then reset asynchronously mid-shift while lit
    push_frame();
    reset  = 1'b0;
    enable = 1'b1;
    n = 0;
    while (!hub_lat && n < 400) begin
      @(negedge clock);
      n++;
    end
    check("first_latch_seen", 64'(hub_lat), 64'd1);
    repeat (3) @(negedge clock);
    check("pre_reset_oe_lit", 64'(hub_oe), 64'd0);
    check("pre_reset_hclk_high", 64'(hub_clk), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_oe", 64'(hub_oe), 64'd1);
    check("async_rst_hclk", 64'(hub_clk), 64'd0);
    check("async_rst_lat", 64'(hub_lat), 64'd0);
    check("async_rst_raddr", 64'(ram_raddr), 64'd0);
    check("frame_starts_run1", 64'(fs_count), 64'd1);
    exp_q.delete();
    fs_cyc.delete();
    fs_count = 0;
    repeat (2) @(negedge clock);

    // Two frames, enable dropped partway through the second one
    push_frame();
    push_frame();
    reset = 1'b0;
    wait_fs(2, 12000);
    repeat (3000) @(negedge clock);
    enable = 1'b0;
    wait_q_empty(12000);
    repeat (100) @(negedge clock);
    idle_window(200);
    check("frame_starts_run2", 64'(fs_count), 64'd2);
    if (fs_cyc.size() >= 2) check("frame_period", 64'(fs_cyc[1] - fs_cyc[0]), 64'(FRAME_CYC));
    else check("frame_period_samples", 64'(fs_cyc.size()), 64'd2);

    // Restart from idle: row 0 plane 0 with a fresh frame_start
    push_frame();
    enable = 1'b1;
    wait_fs(3, 100);
    enable = 1'b0;
    wait_q_empty(12000);
    repeat (100) @(negedge clock);
    idle_window(100);
    check("frame_starts_run3", 64'(fs_count), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
